ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Execute-stage consumer of the decode/execute pipeline register.
- Takes multiply/divide operations issued into EX and runs them iteratively over 33 cycles.
- Holds the architectural HI/LO registers and drives a stall back toward IF/ID and ID/EX.
- Instantiated beside the ALU in EX. Its inputs come directly from the ID/EX register outputs and the forwarding muxes.

Parameters:
- XLEN, 32, operand and HI/LO width; only 32 is supported.
- ITER, 32, iteration count per operation; must equal XLEN.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  valid mul/div operation present in EX this cycle
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- srcA  input  32  forwarded rs value: multiplicand or dividend
- srcB  input  32  forwarded rt value: multiplier or divisor
- hilo_rd  input  1  MFHI/MFLO present in EX this cycle
- hi_we  input  1  MTHI in EX
- lo_we  input  1  MTLO in EX
- wdata  input  32  data for MTHI/MTLO
- flush  input  1  kill the in-flight operation (branch/exception)
- busy  output  1  operation in progress
- stall  output  1  hold IF/ID and ID/EX, bubble EX/MEM
- done  output  1  one-cycle pulse on the cycle HI/LO update
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- States: IDLE, RUN, FIX. Every transition happens on the rising clk edge.
- reset (highest priority, any state) -> state=IDLE, hi=0, lo=0, done=0, busy=0, count=0. An in-flight operation is discarded.
- IDLE and start=1 (accept edge):
  - Latch op, the sign of each operand and the operand magnitudes. For MULT/DIV the magnitude is the two's-complement absolute value, so 0x80000000 stays 0x80000000 unsigned. For MULTU/DIVU operands pass through unchanged.
  - count=0; go to RUN.
- RUN, one iteration per edge, count increments:
  - MUL: shift-add on a 64-bit accumulator.
  - DIV: restoring division; a 33-bit trial subtract per bit.
  - After ITER iterations go to FIX.
- FIX:
  - Apply the sign correction. MULT: negate the 64-bit product if the operand signs differ. DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi (upper product or remainder) and lo (lower product or quotient).
  - Pulse done=1 for exactly this one cycle; go to IDLE.
- Latency: accept at edge 0; hi/lo are valid after edge 33. busy=1 from after edge 0 through edge 33, i.e. busy = (state != IDLE).
- stall = busy & (start | hilo_rd | hi_we | lo_we). A dependent instruction waits in EX until the unit returns to IDLE, then proceeds. stall is combinational; busy, done, hi and lo are registered.
- Divide by zero, no trap: the result is whatever the restoring algorithm plus FIX produces. DIVU x/0 -> lo=0xFFFFFFFF, hi=x. DIV x/0 -> hi=x. lo=0x00000001 for x<0 (all-ones quotient negated, signs differ), 0xFFFFFFFF for x>=0. Latency is the same 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. This is the natural result; no special case.
- MTHI/MTLO while IDLE: hi or lo takes wdata on the next edge. While busy they are stalled and not written.
- start and hi_we/lo_we together in IDLE: start is accepted and the write is dropped. Decode never issues both together.
- start while busy: ignored (stall holds it). Operand inputs are don't-care after the accept edge.
- flush while in RUN or FIX: go to IDLE next edge, hi/lo unchanged, no done. flush with start in IDLE: not accepted. reset beats flush.
- Unused op encodings do not exist; all four codes are defined.

Test Plan:
- MULT srcA=0xFFFFFFFD (-3), srcB=5 -> busy high 33 cycles, done pulses once, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU 100/7 -> lo=14, hi=2.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- Preload hi=0x11 (MTHI), start MULT, assert flush at cycle 10 -> busy drops next edge, hi=0x11 and lo unchanged, done never asserts.
- Start DIVU, then hold hilo_rd=1 from cycle 2 -> stall=1 until busy falls after edge 33, stall=0 on the cycle done=1. A second start during busy is not accepted.
- Assert reset at cycle 20 of an operation -> next edge hi=lo=0, busy=0, done=0. A subsequent MULT 6*7 gives lo=42, hi=0.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: 32 shift-add or restoring-divide
// steps followed by a sign-fix cycle, owning the architectural HI/LO registers.
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            hilo_rd,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(ITER) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state_reg;
    logic [CW-1:0]     count_reg;
    logic              is_div_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic [XLEN-1:0]   opnd_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [2*XLEN-1:0] acc_next;
    logic              busy_reg;
    logic              done_reg;
    logic [XLEN-1:0]   hi_reg;
    logic [XLEN-1:0]   lo_reg;

    // Even op codes are the signed variants; their operands are reduced to magnitudes.
    logic            signed_op;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    assign signed_op = ~op[0];
    assign sign_a    = signed_op & srcA[XLEN-1];
    assign sign_b    = signed_op & srcB[XLEN-1];
    assign mag_a     = sign_a ? (~srcA + 1'b1) : srcA;
    assign mag_b     = sign_b ? (~srcB + 1'b1) : srcB;

    logic [XLEN:0]     add_sum;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   hi_fix;
    logic [XLEN-1:0]   lo_fix;

    // acc holds the product for multiply, and {remainder, quotient shift} for divide.
    always_comb begin
        add_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        div_ge   = acc_reg[2*XLEN-1:XLEN-1] >= {1'b0, opnd_reg};
        div_sub  = acc_reg[2*XLEN-2:XLEN-1] - opnd_reg;
        acc_next = {add_sum, acc_reg[XLEN-1:1]};
        if (is_div_reg) begin
            if (div_ge)
                acc_next = {div_sub, acc_reg[XLEN-2:0], 1'b1};
            else
                acc_next = {acc_reg[2*XLEN-2:0], 1'b0};
        end

        prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
        quo_fix  = neg_q_reg ? (~acc_reg[XLEN-1:0] + 1'b1) : acc_reg[XLEN-1:0];
        rem_fix  = neg_r_reg ? (~acc_reg[2*XLEN-1:XLEN] + 1'b1) : acc_reg[2*XLEN-1:XLEN];
        hi_fix   = is_div_reg ? rem_fix : prod_fix[2*XLEN-1:XLEN];
        lo_fix   = is_div_reg ? quo_fix : prod_fix[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            opnd_reg   <= '0;
            acc_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !flush) begin
                        is_div_reg <= op[1];
                        neg_q_reg  <= sign_a ^ sign_b;
                        neg_r_reg  <= op[1] & sign_a;
                        opnd_reg   <= op[1] ? mag_b : mag_a;
                        acc_reg    <= {{XLEN{1'b0}}, (op[1] ? mag_a : mag_b)};
                        count_reg  <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end else if (!start) begin
                        if (hi_we) hi_reg <= wdata;
                        if (lo_we) lo_reg <= wdata;
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        acc_reg   <= acc_next;
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == CW'(ITER - 1))
                            state_reg <= FIX;
                    end
                end
                FIX: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                    if (!flush) begin
                        hi_reg   <= hi_fix;
                        lo_reg   <= lo_fix;
                        done_reg <= 1'b1;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;
    assign stall = busy_reg & (start | hilo_rd | hi_we | lo_we);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed and random mul/div operations
// against an arithmetic reference, plus flush, stall, and mid-operation reset scenarios.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        hilo_rd = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run = 0;
    int fails = 0;

    ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .hilo_rd(hilo_rd), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        longint sa, sb, q, m;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: r = sa * sb;
            2'd1: r = {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) r = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issues one operation and waits for done, counting busy cycles and done pulses.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output int ndone, output bit finished);
        @(negedge clk);
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; srcA = $urandom; srcB = $urandom;
        nbusy = 0; ndone = 0; finished = 1'b0;
        for (int i = 0; i < 60 && !finished; i++) begin
            if (busy) nbusy++;
            if (done) begin ndone++; finished = 1'b1; end
            if (!finished) @(negedge clk);
        end
        @(negedge clk);
        if (done) ndone++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, stall, hi, lo} !== 67'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b stall=%b hi=%h lo=%h required all zero", busy, done, stall, hi, lo);
        end
        $display("[TB] reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    endtask

    task automatic test_directed();
        logic [1:0]  ops [8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2};
        logic [31:0] as  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFF7, 32'd9};
        logic [31:0] bs  [8] = '{32'd5, 32'hFFFF_FFFF, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
        logic [63:0] exps[8] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001, {32'd2, 32'd14},
                                 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000, {32'd5, 32'hFFFF_FFFF},
                                 64'hFFFF_FFF7_0000_0001, {32'd9, 32'hFFFF_FFFF}};
        int nb, nd;
        bit fin;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], nb, nd, fin);
            tests_run++;
            if ({hi, lo} !== exps[i]) begin
                fails++;
                $display("FAIL directed_%0d: hi:lo=%h required %h", i, {hi, lo}, exps[i]);
            end
            tests_run++;
            if (!fin || nb != 33 || nd != 1) begin
                fails++;
                $display("FAIL directed_timing_%0d: finished=%0d busy_cycles=%0d done_pulses=%0d required 1/33/1", i, fin, nb, nd);
            end
            $display("[TB] directed op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", ops[i], as[i], bs[i], hi, lo, nb);
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [63:0] e;
        int nb, nd;
        bit fin;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            e = model(o, a, b);
            run_op(o, a, b, nb, nd, fin);
            tests_run++;
            if ({hi, lo} !== e || !fin || nb != 33 || nd != 1) begin
                fails++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: hi:lo=%h busy_cycles=%0d done=%0d required %h/33/1",
                         i, o, a, b, {hi, lo}, nb, nd, e);
            end
            $display("[TB] random op=%0d a=%h b=%h -> hi=%h lo=%h", o, a, b, hi, lo);
        end
    endtask

    task automatic test_flush();
        int ndone = 0;
        int nbusy = 0;
        @(negedge clk); hi_we = 1'b1; wdata = 32'h11;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(negedge clk); lo_we = 1'b0;
        tests_run++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            fails++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h required 00000011/00000022", hi, lo);
        end
        @(negedge clk); op = 2'd0; srcA = $urandom; srcB = $urandom; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
            fails++;
            $display("FAIL flush: busy=%b done=%b hi=%h lo=%h required 0/0/00000011/00000022", busy, done, hi, lo);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nbusy++;
        end
        tests_run++;
        if (ndone != 0 || nbusy != 0 || hi !== 32'h11) begin
            fails++;
            $display("FAIL flush_after: done_pulses=%0d busy_cycles=%0d hi=%h required 0/0/00000011", ndone, nbusy, hi);
        end
        $display("[TB] flush: hi=%h lo=%h done_pulses=%0d", hi, lo, ndone);
    endtask

    task automatic test_stall();
        logic [63:0] e;
        logic exp_busy;
        e = model(2'd3, 32'd1000, 32'd3);
        @(negedge clk); op = 2'd3; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 1) hilo_rd = 1'b1;
            if (k == 5) begin start = 1'b1; op = 2'd1; srcA = 32'h1234; srcB = 32'h5678; end
            if (k == 6) start = 1'b0;
            #1;
            exp_busy = (k <= 32);
            tests_run++;
            if (stall !== (hilo_rd & exp_busy) || busy !== exp_busy || done !== (k == 33)) begin
                fails++;
                $display("FAIL stall_cycle_%0d: stall=%b busy=%b done=%b required %b/%b/%b",
                         k, stall, busy, done, hilo_rd & exp_busy, exp_busy, k == 33);
            end
        end
        hilo_rd = 1'b0;
        tests_run++;
        if ({hi, lo} !== e) begin
            fails++;
            $display("FAIL stall_result: hi:lo=%h required %h", {hi, lo}, e);
        end
        $display("[TB] stall: DIVU 1000/3 -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_mid();
        int nb, nd;
        bit fin;
        @(negedge clk); op = 2'd1; srcA = $urandom; srcB = $urandom; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b required zeros", hi, lo, busy, done);
        end
        run_op(2'd0, 32'd6, 32'd7, nb, nd, fin);
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd42 || !fin || nb != 33 || nd != 1) begin
            fails++;
            $display("FAIL mult_after_reset: hi=%h lo=%h busy_cycles=%0d done=%0d required 0/42/33/1", hi, lo, nb, nd);
        end
        $display("[TB] reset_mid then MULT 6*7 -> hi=%h lo=%h", hi, lo);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
